// File: rtl/tlb_unit_pkg.sv
// Shared TLB entry layout, field widths and mask helper.
package tlb_unit_pkg;

    localparam int TLB_LINE_NUM = 16;
    localparam int INDEX_BITS   = $clog2(TLB_LINE_NUM);
    localparam int PFN_BITS     = 20;
    localparam int FLAG_BITS    = 3;
    localparam int VPN2_BITS    = 19;
    localparam int ASID_BITS    = 8;
    localparam int MASK_BITS    = 12;

    typedef struct packed {
        logic [VPN2_BITS-1:0] vpn2;
        logic [ASID_BITS-1:0] asid;
        logic                 g;
        logic [MASK_BITS-1:0] mask;
        logic [PFN_BITS-1:0]  pfn0;
        logic [FLAG_BITS-1:0] c0;
        logic                 d0;
        logic                 v0;
        logic [PFN_BITS-1:0]  pfn1;
        logic [FLAG_BITS-1:0] c1;
        logic                 d1;
        logic                 v1;
    } tlb_entry_t;

    function automatic logic [3:0] mask_width(input logic [MASK_BITS-1:0] m);
        mask_width = '0;
        for (int k = 0; k < MASK_BITS; k++) begin
            mask_width = mask_width + {3'b000, m[k]};
        end
    endfunction

endpackage

// File: rtl/tlb_unit_lookup.sv
// Combinational TLB match, lowest-index priority and even/odd PFN select.
module tlb_lookup #(
    parameter int N     = tlb_unit_pkg::TLB_LINE_NUM,
    parameter int IDX_W = tlb_unit_pkg::INDEX_BITS
) (
    input  tlb_unit_pkg::tlb_entry_t entries [N],
    input  logic [31:0]      va,
    input  logic [7:0]       asid,
    output logic             hit,
    output logic [IDX_W-1:0] idx,
    output logic [19:0]      pfn,
    output logic [2:0]       c,
    output logic             d,
    output logic             v
);
    import tlb_unit_pkg::*;

    tlb_entry_t e;
    logic [3:0] width;
    logic       odd;
    logic       unused;

    assign unused = ^va[11:0];

    always_comb begin
        hit = 1'b0;
        idx = '0;
        e   = '0;
        // Scan downwards so the lowest matching index is the one kept.
        for (int i = N - 1; i >= 0; i--) begin
            if ((((entries[i].vpn2 ^ va[31:13]) & ~{7'b0, entries[i].mask}) == '0)
                && (entries[i].g || entries[i].asid == asid)) begin
                hit = 1'b1;
                idx = i[IDX_W-1:0];
                e   = entries[i];
            end
        end
        width = mask_width(e.mask);
        odd   = va[5'd12 + {1'b0, width}];
        pfn   = odd ? e.pfn1 : e.pfn0;
        c     = odd ? e.c1 : e.c0;
        d     = odd ? e.d1 : e.d0;
        v     = odd ? e.v1 : e.v0;
        // Large pages: masked low PFN bits become page-offset bits.
        for (int k = 0; k < MASK_BITS; k++) begin
            if (e.mask[k]) pfn[k] = va[12+k];
        end
    end

endmodule

// File: rtl/tlb_unit.sv
// Joint MIPS32 TLB: flop storage, CP0 write/read/probe, fetch and data translation.
module tlb_unit #(
    parameter int TLB_LINE_NUM = tlb_unit_pkg::TLB_LINE_NUM,
    parameter int IDX_W        = $clog2(TLB_LINE_NUM)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallM,
    input  logic [3:0]  tlb_typeE,
    input  logic [31:0] entry_hi_W,
    input  logic [31:0] entry_lo0_W,
    input  logic [31:0] entry_lo1_W,
    input  logic [31:0] page_mask_W,
    input  logic [31:0] index_W,
    input  logic [31:0] random_i,
    input  logic [31:0] inst_vaddr,
    input  logic        inst_en,
    input  logic [31:0] data_vaddr,
    input  logic        data_en,
    input  logic        data_wr,
    output logic [31:0] inst_paddr,
    output logic        inst_uncached,
    output logic        inst_tlb_refill,
    output logic        inst_tlb_invalid,
    output logic [31:0] data_paddr,
    output logic        data_uncached,
    output logic        data_tlb_refill,
    output logic        data_tlb_invalid,
    output logic        data_tlb_modify,
    output logic [31:0] index_in,
    output logic [31:0] entry_hi_in,
    output logic [31:0] entry_lo0_in,
    output logic [31:0] entry_lo1_in,
    output logic [31:0] page_mask_in
);
    import tlb_unit_pkg::*;

    tlb_entry_t       tlb [TLB_LINE_NUM];
    tlb_entry_t       wr_entry;
    tlb_entry_t       rd;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;

    logic             i_hit, d_hit, p_hit;
    logic [IDX_W-1:0] i_idx, d_idx, p_idx;
    logic [19:0]      i_pfn, d_pfn, p_pfn;
    logic [2:0]       i_c, d_c, p_c;
    logic             i_d, d_d, p_d;
    logic             i_v, d_v, p_v;
    logic             i_unmapped, d_unmapped;
    logic             unused;

    assign wr_en  = !stallM && (tlb_typeE[3] || tlb_typeE[2]);
    assign wr_idx = tlb_typeE[3] ? random_i[IDX_W-1:0] : index_W[IDX_W-1:0];

    always_comb begin
        wr_entry      = '0;
        wr_entry.mask = page_mask_W[24:13];
        wr_entry.vpn2 = entry_hi_W[31:13] & ~{7'b0, page_mask_W[24:13]};
        wr_entry.asid = entry_hi_W[7:0];
        wr_entry.g    = entry_lo0_W[0] & entry_lo1_W[0];
        wr_entry.pfn0 = entry_lo0_W[25:6];
        wr_entry.c0   = entry_lo0_W[5:3];
        wr_entry.d0   = entry_lo0_W[2];
        wr_entry.v0   = entry_lo0_W[1];
        wr_entry.pfn1 = entry_lo1_W[25:6];
        wr_entry.c1   = entry_lo1_W[5:3];
        wr_entry.d1   = entry_lo1_W[2];
        wr_entry.v1   = entry_lo1_W[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TLB_LINE_NUM; i++) tlb[i] <= '0;
        end else if (wr_en) begin
            tlb[wr_idx] <= wr_entry;
        end
    end

    tlb_lookup #(.N(TLB_LINE_NUM), .IDX_W(IDX_W)) u_inst (
        .entries(tlb), .va(inst_vaddr), .asid(entry_hi_W[7:0]),
        .hit(i_hit), .idx(i_idx), .pfn(i_pfn), .c(i_c), .d(i_d), .v(i_v)
    );

    tlb_lookup #(.N(TLB_LINE_NUM), .IDX_W(IDX_W)) u_data (
        .entries(tlb), .va(data_vaddr), .asid(entry_hi_W[7:0]),
        .hit(d_hit), .idx(d_idx), .pfn(d_pfn), .c(d_c), .d(d_d), .v(d_v)
    );

    tlb_lookup #(.N(TLB_LINE_NUM), .IDX_W(IDX_W)) u_probe (
        .entries(tlb), .va(entry_hi_W), .asid(entry_hi_W[7:0]),
        .hit(p_hit), .idx(p_idx), .pfn(p_pfn), .c(p_c), .d(p_d), .v(p_v)
    );

    // kseg0/kseg1 bypass the TLB entirely.
    assign i_unmapped = inst_vaddr[31:30] == 2'b10;
    assign d_unmapped = data_vaddr[31:30] == 2'b10;

    always_comb begin
        inst_paddr       = i_unmapped ? {3'b000, inst_vaddr[28:0]}
                                      : {i_pfn, inst_vaddr[11:0]};
        inst_uncached    = i_unmapped ? inst_vaddr[29] : (i_c == 3'd2);
        inst_tlb_refill  = inst_en & ~i_unmapped & ~i_hit;
        inst_tlb_invalid = inst_en & ~i_unmapped & i_hit & ~i_v;

        data_paddr       = d_unmapped ? {3'b000, data_vaddr[28:0]}
                                      : {d_pfn, data_vaddr[11:0]};
        data_uncached    = d_unmapped ? data_vaddr[29] : (d_c == 3'd2);
        data_tlb_refill  = data_en & ~d_unmapped & ~d_hit;
        data_tlb_invalid = data_en & ~d_unmapped & d_hit & ~d_v;
        data_tlb_modify  = data_en & data_wr & ~d_unmapped & d_hit & d_v & ~d_d;
    end

    assign index_in = p_hit ? {{(32-IDX_W){1'b0}}, p_idx} : 32'h8000_0000;

    assign rd           = tlb[index_W[IDX_W-1:0]];
    assign entry_hi_in  = {rd.vpn2, 5'b0, rd.asid};
    assign entry_lo0_in = {6'b0, rd.pfn0, rd.c0, rd.d0, rd.v0, rd.g};
    assign entry_lo1_in = {6'b0, rd.pfn1, rd.c1, rd.d1, rd.v1, rd.g};
    assign page_mask_in = {7'b0, rd.mask, 13'b0};

    assign unused = ^{entry_hi_W[12:8], entry_lo0_W[31:26], entry_lo1_W[31:26],
                      page_mask_W[31:25], page_mask_W[12:0], index_W, random_i,
                      tlb_typeE[1:0], i_idx, d_idx, i_d, p_pfn, p_c, p_d, p_v};

endmodule

// File: tb/tb_tlb_unit.sv
// Directed-vector bench for tlb_unit with hand-computed expectations.
module tb_tlb_unit;

    localparam logic [3:0] TLBWR = 4'b1000;
    localparam logic [3:0] TLBWI = 4'b0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallM;
    logic [3:0]  tlb_typeE;
    logic [31:0] entry_hi_W, entry_lo0_W, entry_lo1_W, page_mask_W;
    logic [31:0] index_W, random_i;
    logic [31:0] inst_vaddr, data_vaddr;
    logic        inst_en, data_en, data_wr;
    logic [31:0] inst_paddr, data_paddr;
    logic        inst_uncached, inst_tlb_refill, inst_tlb_invalid;
    logic        data_uncached, data_tlb_refill, data_tlb_invalid;
    logic        data_tlb_modify;
    logic [31:0] index_in, entry_hi_in, entry_lo0_in, entry_lo1_in;
    logic [31:0] page_mask_in;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    tlb_unit dut (
        .clk(clk), .rst(rst), .stallM(stallM), .tlb_typeE(tlb_typeE),
        .entry_hi_W(entry_hi_W), .entry_lo0_W(entry_lo0_W),
        .entry_lo1_W(entry_lo1_W), .page_mask_W(page_mask_W),
        .index_W(index_W), .random_i(random_i),
        .inst_vaddr(inst_vaddr), .inst_en(inst_en),
        .data_vaddr(data_vaddr), .data_en(data_en), .data_wr(data_wr),
        .inst_paddr(inst_paddr), .inst_uncached(inst_uncached),
        .inst_tlb_refill(inst_tlb_refill), .inst_tlb_invalid(inst_tlb_invalid),
        .data_paddr(data_paddr), .data_uncached(data_uncached),
        .data_tlb_refill(data_tlb_refill), .data_tlb_invalid(data_tlb_invalid),
        .data_tlb_modify(data_tlb_modify), .index_in(index_in),
        .entry_hi_in(entry_hi_in), .entry_lo0_in(entry_lo0_in),
        .entry_lo1_in(entry_lo1_in), .page_mask_in(page_mask_in)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tlbw(input logic [3:0] t, input logic [31:0] hi,
                        input logic [31:0] lo0, input logic [31:0] lo1,
                        input logic [31:0] pm, input logic [31:0] idx,
                        input logic [31:0] rnd);
        tlb_typeE   = t;
        entry_hi_W  = hi;
        entry_lo0_W = lo0;
        entry_lo1_W = lo1;
        page_mask_W = pm;
        index_W     = idx;
        random_i    = rnd;
        @(posedge clk);
        #1;
        tlb_typeE = 4'b0000;
    endtask

    initial begin
        rst = 1'b1; stallM = 1'b0; tlb_typeE = '0;
        entry_hi_W = '0; entry_lo0_W = '0; entry_lo1_W = '0;
        page_mask_W = '0; index_W = '0; random_i = '0;
        inst_vaddr = '0; inst_en = 1'b0;
        data_vaddr = '0; data_en = 1'b0; data_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        index_W = 32'd3;
        #1;
        chk("rst_tlbr_hi", entry_hi_in, 32'h0);
        chk("rst_tlbr_lo0", entry_lo0_in, 32'h0);
        chk("rst_tlbr_pm", page_mask_in, 32'h0);

        inst_en = 1'b1; inst_vaddr = 32'h0040_0000;
        #1;
        chk("rst_refill", {31'b0, inst_tlb_refill}, 32'h1);
        inst_vaddr = 32'hBFC0_0000;
        #1;
        chk("kseg1_paddr", inst_paddr, 32'h1FC0_0000);
        chk("kseg1_flags", {29'b0, inst_uncached, inst_tlb_refill,
                            inst_tlb_invalid}, 32'h4);
        inst_vaddr = 32'h8000_1234;
        #1;
        chk("kseg0_paddr", inst_paddr, 32'h0000_1234);
        chk("kseg0_cached", {31'b0, inst_uncached}, 32'h0);
        inst_en = 1'b0; inst_vaddr = 32'h0040_0000;
        #1;
        chk("en0_noflag", {30'b0, inst_tlb_refill, inst_tlb_invalid}, 32'h0);

        // tlbwi entry 3: even page PFN 0x41 V=1 D=1, odd page invalid
        tlbw(TLBWI, 32'h0040_0005, 32'h0000_1046, 32'h0, 32'h0, 32'd3, 32'd0);
        data_en = 1'b1; data_wr = 1'b0; data_vaddr = 32'h0040_0123;
        #1;
        chk("e3_paddr", data_paddr, 32'h0004_1123);
        chk("e3_flags", {27'b0, data_uncached, data_tlb_refill,
                         data_tlb_invalid, data_tlb_modify, 1'b0}, 32'h0);
        data_vaddr = 32'h0040_1000;
        #1;
        chk("e3_odd_inv", {29'b0, data_tlb_refill, data_tlb_invalid,
                           data_tlb_modify}, 32'h2);
        inst_en = 1'b1; inst_vaddr = 32'h0040_0abc;
        #1;
        chk("e3_inst_paddr", inst_paddr, 32'h0004_1abc);

        // Entry 5: PFN 0x55, C=2, D=0, V=1
        tlbw(TLBWI, 32'h0080_0005, 32'h0000_1552, 32'h0, 32'h0, 32'd5, 32'd0);
        data_vaddr = 32'h0080_0010; data_wr = 1'b1;
        #1;
        chk("mod_flags", {29'b0, data_tlb_refill, data_tlb_invalid,
                          data_tlb_modify}, 32'h1);
        chk("mod_paddr", data_paddr, 32'h0005_5010);
        chk("mod_uncached", {31'b0, data_uncached}, 32'h1);
        data_wr = 1'b0;
        #1;
        chk("load_noflag", {29'b0, data_tlb_refill, data_tlb_invalid,
                            data_tlb_modify}, 32'h0);
        data_wr = 1'b1; data_en = 1'b0;
        #1;
        chk("en0_nomod", {31'b0, data_tlb_modify}, 32'h0);
        data_en = 1'b1; data_wr = 1'b0;

        // Probe
        entry_hi_W = 32'h0040_0005;
        #1;
        chk("probe_hit3", index_in, 32'h3);
        entry_hi_W = 32'h0040_0006;
        #1;
        chk("probe_asid_miss", index_in, 32'h8000_0000);
        tlbw(TLBWI, 32'h0040_0005, 32'h0000_1047, 32'h0000_0001, 32'h0,
             32'd3, 32'd0);
        entry_hi_W = 32'h0040_0006;
        #1;
        chk("probe_global", index_in, 32'h3);
        chk("tlbr3_lo0", entry_lo0_in, 32'h0000_1047);
        chk("tlbr3_lo1", entry_lo1_in, 32'h0000_0001);

        // tlbwr to entry 9, first stalled then free
        stallM = 1'b1;
        tlbw(TLBWR, 32'h1234_5607, 32'h0000_4006, 32'h0000_4102,
             32'h0000_6000, 32'd9, 32'd9);
        #1;
        chk("stall_nowrite", entry_hi_in, 32'h0);
        stallM = 1'b0;
        tlbw(TLBWR, 32'h1234_5607, 32'h0000_4006, 32'h0000_4102,
             32'h0000_6000, 32'd9, 32'd9);
        #1;
        chk("tlbr9_hi", entry_hi_in, 32'h1234_0007);
        chk("tlbr9_lo0", entry_lo0_in, 32'h0000_4006);
        chk("tlbr9_lo1", entry_lo1_in, 32'h0000_4102);
        chk("tlbr9_pm", page_mask_in, 32'h0000_6000);
        data_vaddr = 32'h1234_5678;
        #1;
        chk("big_page_paddr", data_paddr, 32'h0010_5678);
        chk("big_page_flags", {30'b0, data_tlb_refill, data_tlb_invalid},
            32'h0);

        // Same-cycle write and lookup: old mapping, then new one
        entry_hi_W = 32'h0040_0005; entry_lo0_W = 32'h0000_1DC6;
        entry_lo1_W = 32'h0; page_mask_W = 32'h0; index_W = 32'd3;
        data_vaddr = 32'h0040_0123; tlb_typeE = TLBWI;
        #1;
        chk("wr_cycle_old", data_paddr, 32'h0004_1123);
        @(posedge clk);
        #1;
        tlb_typeE = 4'b0000;
        #1;
        chk("wr_next_new", data_paddr, 32'h0007_7123);

        // Reset wins over a concurrent write
        tlb_typeE = TLBWI; index_W = 32'd3; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; tlb_typeE = 4'b0000;
        #1;
        chk("rst_mid_write_hi", entry_hi_in, 32'h0);
        chk("rst_mid_write_lo0", entry_lo0_in, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
